// File: rtl/md_format_encoder.sv
// MD/MDS-form rotate-doubleword instruction encoder with output FIFO.
// Builds primary-opcode-30 words from symbolic requests and queues them.
module md_format_encoder #(
  parameter int instructionWidth = 32,
  parameter int regWidth         = 5,
  parameter int immWidth         = 6,
  parameter int fifoDepth        = 4,
  parameter int countWidth       = 16
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [2:0]                  op_i,
  input  logic [regWidth-1:0]         rs_i,
  input  logic [regWidth-1:0]         ra_i,
  input  logic [regWidth-1:0]         rb_i,
  input  logic [immWidth-1:0]         sh_i,
  input  logic [immWidth-1:0]         mb_i,
  input  logic                        rc_i,
  output logic [instructionWidth-1:0] instruction_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        illegal_o,
  output logic [countWidth-1:0]       issued_count_o
);

  localparam int PtrW = $clog2(fifoDepth);
  localparam logic [PtrW:0] FullOcc = (PtrW+1)'(fifoDepth);

  logic [instructionWidth-1:0] mem_q [fifoDepth];

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]         occ_q, occ_d;
  logic                  illegal_q, illegal_d;
  logic [countWidth-1:0] count_q, count_d;

  logic                        legal;
  logic [regWidth-1:0]         f_mid;
  logic [3:0]                  f_xo;
  logic [instructionWidth-1:0] word;
  logic                        full;
  logic                        empty;
  logic                        accept;
  logic                        push;
  logic                        pop;

  // Field [16:20] and the extended opcode [27:30] differ by form.
  always_comb begin
    legal = 1'b0;
    f_mid = '0;
    f_xo  = '0;
    case (op_i)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        legal = 1'b1;
        f_mid = sh_i[4:0];
        f_xo  = {op_i, sh_i[5]};
      end
      3'd4: begin
        legal = 1'b1;
        f_mid = rb_i;
        f_xo  = 4'b1000;
      end
      3'd5: begin
        legal = 1'b1;
        f_mid = rb_i;
        f_xo  = 4'b1001;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // mb is split: low five bits first, its MSB lands in bit 26.
  always_comb begin
    word = {6'd30, rs_i, ra_i, f_mid,
            mb_i[4:0], mb_i[5], f_xo, rc_i};
  end

  always_comb begin
    full   = (occ_q == FullOcc);
    empty  = (occ_q == '0);
    accept = in_valid_i && !full;
    push   = accept && legal;
    pop    = !empty && out_ready_i;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    count_d   = count_q;
    illegal_d = accept && !legal;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset; pointers and occupancy define validity.
  always_ff @(posedge clock_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

  assign in_ready_o     = !full;
  assign out_valid_o    = !empty;
  assign instruction_o  = mem_q[rd_ptr_q];
  assign illegal_o      = illegal_q;
  assign issued_count_o = count_q;

endmodule

// File: tb/tb_md_format_encoder.sv
// Self-checking bench for md_format_encoder: queue-based reference
// model compared every cycle, plus hand-computed literal checks.
module tb_md_format_encoder;

  logic        clk;
  logic        reset_i;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [4:0]  rs, ra, rb;
  logic [5:0]  sh, mb;
  logic        rc;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic        illegal;
  logic [15:0] issued;

  int tests = 0;
  int fails = 0;

  md_format_encoder dut (
    .clock_i        (clk),
    .reset_i        (reset_i),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .op_i           (op),
    .rs_i           (rs),
    .ra_i           (ra),
    .rb_i           (rb),
    .sh_i           (sh),
    .mb_i           (mb),
    .rc_i           (rc),
    .instruction_o  (instr),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .illegal_o      (illegal),
    .issued_count_o (issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Place an n-bit value at big-endian bit positions p..p+n-1.
  function automatic logic [31:0] put(input logic [31:0] w, input int p,
                                      input int n, input int v);
    logic [31:0] r;
    r = w;
    for (int k = 0; k < n; k++) r[31-(p+k)] = 1'((v >> (n-1-k)) & 1);
    return r;
  endfunction

  function automatic logic [31:0] enc(input int o, input int s, input int a,
                                      input int b, input int shv,
                                      input int mbv, input int r);
    logic [31:0] w;
    w = '0;
    w = put(w, 0, 6, 30);
    w = put(w, 6, 5, s);
    w = put(w, 11, 5, a);
    w = put(w, 21, 5, mbv % 32);
    w = put(w, 26, 1, mbv / 32);
    w = put(w, 31, 1, r);
    if (o < 4) begin
      w = put(w, 16, 5, shv % 32);
      w = put(w, 27, 3, o);
      w = put(w, 30, 1, shv / 32);
    end else begin
      w = put(w, 16, 5, b);
      w = put(w, 27, 4, (o == 4) ? 8 : 9);
    end
    return w;
  endfunction

  // Reference model: updated on every rising edge from sampled inputs.
  logic [31:0] mq[$];
  logic [15:0] mcount;
  logic        mill;
  bit          live = 0;
  bit          macc, mpop;

  always @(posedge clk) begin
    if (reset_i) begin
      mq.delete();
      mcount = 0;
      mill   = 0;
      live   = 1;
    end else if (live) begin
      macc = in_valid && (mq.size() < 4);
      mpop = (mq.size() > 0) && out_ready;
      mill = macc && (op >= 3'd6);
      if (mpop) begin
        void'(mq.pop_front());
        mcount = mcount + 16'd1;
      end
      if (macc && op < 3'd6)
        mq.push_back(enc(int'(op), int'(rs), int'(ra), int'(rb),
                         int'(sh), int'(mb), int'(rc)));
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("m_in_ready", 32'(in_ready), 32'(mq.size() < 4));
      chk("m_illegal", 32'(illegal), 32'(mill));
      chk("m_count", 32'(issued), 32'(mcount));
      if (mq.size() != 0) chk("m_word", instr, mq[0]);
    end
  end

  task automatic push(input int o, input int s, input int a, input int b,
                      input int shv, input int mbv, input int r);
    bit done;
    @(posedge clk);
    #2;
    op = 3'(o); rs = 5'(s); ra = 5'(a); rb = 5'(b);
    sh = 6'(shv); mb = 6'(mbv); rc = 1'(r);
    in_valid = 1'b1;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #2;
        done = 1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: got stalled expected accept");
    end
    in_valid = 1'b0;
  endtask

  bit done5 = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1; in_valid = 0; out_ready = 0;
    op = 0; rs = 0; ra = 0; rb = 0; sh = 0; mb = 0; rc = 0;

    chk("enc_rldicl", enc(0, 3, 4, 0, 1, 0, 0), 32'h78640800);
    chk("enc_rldicr", enc(1, 3, 4, 0, 32, 32, 1), 32'h78640027);
    chk("enc_rldcl", enc(4, 3, 4, 5, 0, 0, 0), 32'h78642810);
    chk("enc_rldcr", enc(5, 3, 4, 5, 0, 0, 0), 32'h78642812);

    repeat (2) @(posedge clk);
    #2 reset_i = 0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(issued), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);

    out_ready = 1;
    push(0, 3, 4, 0, 1, 0, 0);
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_word", instr, 32'h78640800);
    @(negedge clk);
    chk("t1_count", 32'(issued), 32'd1);

    push(1, 3, 4, 0, 32, 32, 1);
    @(negedge clk);
    chk("t2_word", instr, 32'h78640027);

    push(4, 3, 4, 5, 0, 0, 0);
    @(negedge clk);
    chk("t3_rldcl", instr, 32'h78642810);
    push(5, 3, 4, 5, 0, 0, 0);
    @(negedge clk);
    chk("t3_rldcr", instr, 32'h78642812);
    repeat (3) @(negedge clk);
    chk("t3_count", 32'(issued), 32'd4);

    out_ready = 0;
    push(2, 1, 2, 0, 63, 63, 1);
    push(3, 31, 0, 0, 17, 5, 0);
    push(4, 7, 8, 31, 0, 33, 1);
    push(0, 9, 10, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4_full", 32'(in_ready), 32'd0);
    fork
      begin
        push(5, 12, 13, 14, 0, 40, 1);
        done5 = 1;
      end
    join_none
    repeat (3) @(negedge clk);
    chk("t4_stalled", 32'(done5), 32'd0);
    @(posedge clk);
    #2 out_ready = 1;
    for (int i = 0; i < 30 && !(done5 && mq.size() == 0); i++)
      @(negedge clk);
    chk("t4_done5", 32'(done5), 32'd1);
    @(negedge clk);
    chk("t4_count", 32'(issued), 32'd9);

    push(6, 1, 1, 1, 1, 1, 1);
    @(negedge clk);
    chk("t5_illegal", 32'(illegal), 32'd1);
    chk("t5_empty", 32'(out_valid), 32'd0);
    push(0, 20, 21, 0, 2, 3, 0);
    @(negedge clk);
    chk("t5_ill_gone", 32'(illegal), 32'd0);
    chk("t5_word", instr, enc(0, 20, 21, 0, 2, 3, 0));
    repeat (3) @(negedge clk);
    chk("t5_count", 32'(issued), 32'd10);

    out_ready = 0;
    push(1, 2, 3, 0, 4, 5, 0);
    push(2, 3, 4, 0, 5, 6, 1);
    push(4, 4, 5, 6, 0, 7, 0);
    @(posedge clk);
    #2;
    reset_i = 1; in_valid = 1; op = 0; out_ready = 1;
    @(posedge clk);
    #2;
    reset_i = 0; in_valid = 0;
    @(negedge clk);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_count", 32'(issued), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("t6_no_emit", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
